// File: rtl/busca_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : busca_sequenciador
// Description : Instruction fetch and step sequencer for the 16-bit datapath.
//               It fetches one word from program memory, holds it in the
//               instruction register and walks the 2-bit execution step
//               (00..11) seen by the downstream control unit. It also owns
//               the program counter and the run/halt status.
//
//               Instruction timing: FETCH, WAIT, then four EXEC cycles, with
//               done on the last one. Back-to-back throughput is one
//               instruction every 6 cycles.
//
// Optional    : `define SINGLE_STEP_EN adds input step_req. In EXEC, step
//               (including the completing step=11) advances only on cycles
//               with step_req=1. FETCH and WAIT are unaffected.
//
// Ports       : clock     - system clock, rising edge
//               resetn    - asynchronous active-low reset
//               run       - 1 = fetch/execute, 0 = stop after current instr
//               clear     - synchronous restart (PC=0, IDLE), top priority
//               step_req  - (SINGLE_STEP_EN only) EXEC advance request
//               mem_rdata - program memory data, valid 1 cycle after mem_rd
//               mem_addr  - program memory address (always equals pc)
//               mem_rd    - memory read strobe (FETCH state)
//               instrucao - instruction register to the control unit
//               step      - execution step to the control unit
//               busy      - 1 in FETCH, WAIT, EXEC
//               done      - one-cycle pulse on the completing step=11 cycle
//               halted    - 1 in HALT
//               pc        - current program counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module busca_sequenciador #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned INSTR_W   = 16,    // the current ISA needs 16
    parameter int unsigned LAST_ADDR = 8'hFF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               run,
    input  logic               clear,
`ifdef SINGLE_STEP_EN
    input  logic               step_req,
`endif
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic [INSTR_W-1:0] instrucao,
    output logic [1:0]         step,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [1:0]        STEP_LAST = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q,    pc_d;
    logic [INSTR_W-1:0]   ir_q,    ir_d;
    logic [1:0]           step_q,  step_d;

    logic                 w_advance;    // EXEC may move on this cycle
    logic                 w_complete;   // last step of an instruction retires

`ifdef SINGLE_STEP_EN
    assign w_advance = step_req;
`else
    assign w_advance = 1'b1;
`endif

    // A clear in the completing cycle aborts the instruction, so it also
    // suppresses the done pulse and the PC increment.
    assign w_complete = (state_q == S_EXEC) && (step_q == STEP_LAST)
                        && w_advance && !clear;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        step_d  = step_q;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Memory answers one cycle after the FETCH strobe.
                ir_d    = mem_rdata;
                step_d  = 2'b00;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (w_advance) begin
                    if (step_q == STEP_LAST) begin
                        step_d = 2'b00;
                        pc_d   = pc_q + PC_ONE;
                        // The halt test uses the PC of the retiring word,
                        // i.e. the value before the increment.
                        if (pc_q == LAST_PC) begin
                            state_d = S_HALT;
                        end else if (run) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        step_d = step_q + 2'b01;
                    end
                end
            end

            S_HALT: begin
                // Only clear or reset leave HALT; run is ignored.
                step_d = 2'b00;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d = S_IDLE;
            pc_d    = '0;
            ir_d    = '0;
            step_d  = 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            step_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so reset clears them at once)
    // ------------------------------------------------------------------
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign instrucao = ir_q;
    assign step      = step_q;
    assign mem_rd    = (state_q == S_FETCH);
    assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT)
                       || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);
    assign done      = w_complete;

endmodule
`default_nettype wire

// File: tb/tb_busca_sequenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_busca_sequenciador
// Description : Self-checking bench for busca_sequenciador. The DUT is built
//               with LAST_ADDR=2 so the halt path is reached quickly. Each
//               scenario task compares the full observable output vector
//               {mem_rd,busy,done,halted,step,pc,mem_addr,instrucao} each
//               cycle against an expectation derived from instruction timing
//               (FETCH, WAIT, 4 x EXEC) and a memory array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busca_sequenciador;

    localparam int LAST = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        run;
    logic        clear;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] instrucao;
    logic [1:0]  step;
    logic        busy;
    logic        done;
    logic        halted;
    logic [7:0]  pc;
`ifdef SINGLE_STEP_EN
    logic        step_req = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [256];
    logic [37:0] obs;
    logic [37:0] e;

    busca_sequenciador #(
        .ADDR_W    (8),
        .INSTR_W   (16),
        .LAST_ADDR (LAST)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .clear     (clear),
`ifdef SINGLE_STEP_EN
        .step_req  (step_req),
`endif
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .instrucao (instrucao),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .halted    (halted),
        .pc        (pc)
    );

    always #5 clock = ~clock;

    // Program memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 16'($urandom);
    end

    assign obs = {mem_rd, busy, done, halted, step, pc, mem_addr, instrucao};

    // Expected outputs k cycles after an instruction enters FETCH at pc p.
    function automatic logic [37:0] exp_busy(input int k, input logic [7:0] p,
                                             input logic [15:0] ir_prev,
                                             input logic [15:0] ir_new);
        logic [1:0]  s;
        logic [15:0] ir;
        s  = (k >= 2) ? 2'(k - 2) : 2'b00;
        ir = (k >= 2) ? ir_new : ir_prev;
        return {(k == 0), 1'b1, (k == 5), 1'b0, s, p, p, ir};
    endfunction

    // Expected outputs while not executing (IDLE or HALT).
    function automatic logic [37:0] exp_rest(input logic hlt, input logic [7:0] p,
                                             input logic [15:0] ir);
        return {3'b000, hlt, 2'b00, p, p, ir};
    endfunction

    task automatic test_reset();
        resetn = 1'b0; run = 1'b0; clear = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== 38'd0) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", obs, 38'd0);
        end
        resetn = 1'b1;
        @(negedge clock);
        e = exp_rest(1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_single();
        mem[0] = 16'h1234;
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            e = exp_busy(k, 8'd0, 16'd0, 16'h1234);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL single k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 5) run = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            e = exp_rest(1'b0, 8'd1, 16'h1234);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL single_idle j=%0d got=%h exp=%h", j, obs, e);
            end
        end
    endtask

    task automatic test_run_drop();
        int drop;
        drop = $urandom_range(0, 3);
        mem[1] = 16'($urandom);
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            e = exp_busy(k, 8'd1, 16'h1234, mem[1]);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL run_drop k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 2 + drop || k == 3) run = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            e = exp_rest(1'b0, 8'd2, mem[1]);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL run_drop_idle j=%0d got=%h exp=%h", j, obs, e);
            end
        end
    endtask

    task automatic test_clear_abort();
        logic [15:0] prev;
        prev = mem[1];
        mem[2] = 16'($urandom);
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            e = exp_busy(k, 8'd2, prev, mem[2]);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL clear_abort k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 4) clear = 1'b1;   // step=10
        end
        // clear held with run high: stays IDLE, zeroed.
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            e = exp_rest(1'b0, 8'd0, 16'd0);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL clear_abort_idle j=%0d got=%h exp=%h", j, obs, e);
            end
        end
        clear = 1'b0; run = 1'b0;
        @(negedge clock);
        e = exp_rest(1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL clear_abort_after got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_back_to_back_halt();
        logic [15:0] prev;
        prev = 16'd0;
        for (int w = 0; w <= LAST; w++) mem[w] = 16'hA001 + 16'(w);
        run = 1'b1;
        for (int i = 0; i <= LAST; i++) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                e = exp_busy(k, 8'(i), prev, mem[i]);
                checks++;
                if (obs !== e) begin
                    failures++; $display("FAIL b2b i=%0d k=%0d got=%h exp=%h", i, k, obs, e);
                end
            end
            prev = mem[i];
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clock);
            e = exp_rest(1'b1, 8'(LAST + 1), prev);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL halt_hold j=%0d got=%h exp=%h", j, obs, e);
            end
            run = 1'($urandom_range(0, 1));
        end
        clear = 1'b1; run = 1'b1;
        @(negedge clock);
        e = exp_rest(1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL halt_clear got=%h exp=%h", obs, e);
        end
        clear = 1'b0;
        @(negedge clock);
        e = exp_busy(0, 8'd0, 16'd0, mem[0]);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL clear_release_fetch got=%h exp=%h", obs, e);
        end
        clear = 1'b1;
        @(negedge clock);
        e = exp_rest(1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL fetch_clear got=%h exp=%h", obs, e);
        end
        clear = 1'b0; run = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  p;
        logic [15:0] ir;
        int mode, abortk, aborts, aborted, n;
        for (int it = 0; it < 6; it++) begin
            clear = 1'b1; run = 1'b0;
            @(negedge clock);
            e = exp_rest(1'b0, 8'd0, 16'd0);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL rnd_start it=%0d got=%h exp=%h", it, obs, e);
            end
            clear = 1'b0;
            for (int w = 0; w <= LAST; w++) mem[w] = 16'($urandom);
            p = 8'd0; ir = 16'd0; aborts = 0; run = 1'b1;
            while (p <= 8'(LAST)) begin
                mode    = (aborts < 2) ? $urandom_range(0, 2) : $urandom_range(0, 1);
                abortk  = (mode == 2) ? $urandom_range(0, 4) : 99;
                aborted = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    e = exp_busy(k, p, ir, mem[p]);
                    checks++;
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL rnd it=%0d pc=%0d k=%0d got=%h exp=%h", it, p, k, obs, e);
                    end
                    if (k == abortk) begin
                        clear = 1'b1; aborted = 1; break;
                    end
                    if (k == 5 && mode == 1) run = 1'b0;
                end
                if (aborted != 0) begin
                    @(negedge clock);
                    e = exp_rest(1'b0, 8'd0, 16'd0);
                    checks++;
                    if (obs !== e) begin
                        failures++; $display("FAIL rnd_abort it=%0d got=%h exp=%h", it, obs, e);
                    end
                    clear = 1'b0; p = 8'd0; ir = 16'd0; aborts++;
                end else begin
                    ir = mem[p];
                    p  = p + 8'd1;
                    if (mode == 1 && p <= 8'(LAST)) begin
                        n = $urandom_range(1, 3);
                        for (int j = 0; j < n; j++) begin
                            @(negedge clock);
                            e = exp_rest(1'b0, p, ir);
                            checks++;
                            if (obs !== e) begin
                                failures++; $display("FAIL rnd_idle it=%0d got=%h exp=%h", it, obs, e);
                            end
                            if (j == n - 1) run = 1'b1;
                        end
                    end
                end
            end
            for (int j = 0; j < 3; j++) begin
                @(negedge clock);
                e = exp_rest(1'b1, p, ir);
                checks++;
                if (obs !== e) begin
                    failures++; $display("FAIL rnd_halt it=%0d got=%h exp=%h", it, obs, e);
                end
                run = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_async_reset();
        clear = 1'b1; run = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        mem[0] = 16'($urandom);
        run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            e = exp_busy(k, 8'd0, 16'd0, mem[0]);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL async_pre k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        // Now in WAIT; drop reset between clock edges.
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs !== 38'd0) begin
            failures++; $display("FAIL async_immediate got=%h exp=%h", obs, 38'd0);
        end
        @(negedge clock);
        checks++;
        if (obs !== 38'd0) begin
            failures++; $display("FAIL async_held got=%h exp=%h", obs, 38'd0);
        end
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            e = exp_busy(k, 8'd0, 16'd0, mem[0]);
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL async_restart k=%0d got=%h exp=%h", k, obs, e);
            end
            if (k == 5) run = 1'b0;
        end
        @(negedge clock);
        e = exp_rest(1'b0, 8'd1, mem[0]);
        checks++;
        if (obs !== e) begin
            failures++; $display("FAIL async_end got=%h exp=%h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_run_drop();
        test_clear_abort();
        test_back_to_back_halt();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
